lcd_init_seq: RTL



---
 rtl/lcd_init_seq.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/lcd_init_seq.sv
// Panel bring-up sequencer: pulses the panel hardware reset, then clocks a fixed
// ST7789-style init list out over a 4-wire SPI (mode 0, MSB first) and pulses o_done.
//
// state        | meaning
// S_IDLE       | waiting for i_start, SPI idle, panel reset released
// S_HWRST_LOW  | o_lcd_rst held low for RST_PULSE cycles
// S_HWRST_WAIT | panel recovering from hardware reset, RST_WAIT cycles
// S_LOAD       | fetch table entry, drop CS, present bit 7
// S_SHIFT      | 8 SCLK periods, data changes on falling edges
// S_GAP        | CS high for CLK_DIV cycles after each byte
// S_DELAY      | extra CMD_DELAY idle after delay-flagged entries
// S_DONE       | one-cycle completion pulse, back to idle
module lcd_init_seq #(
   parameter int         CLK_DIV    = 2,
   parameter int         RST_PULSE  = 270_000,
   parameter int         RST_WAIT   = 3_240_000,
   parameter int         CMD_DELAY  = 3_240_000,
   parameter logic [7:0] COLMOD_VAL = 8'h66,
   parameter logic [7:0] MADCTL_VAL = 8'h00
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_start,
   output logic o_lcd_rst,
   output logic o_sclk,
   output logic o_mosi,
   output logic o_dc,
   output logic o_cs,
   output logic o_busy,
   output logic o_done
);

   localparam int CNT_MAX_A = (RST_PULSE > RST_WAIT) ? RST_PULSE : RST_WAIT;
   localparam int CNT_MAX   = (CNT_MAX_A > CMD_DELAY) ? CNT_MAX_A : CMD_DELAY;
   localparam int CW        = $clog2(CNT_MAX + 1);
   localparam int DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [3:0]    LAST_IDX = 4'd8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HWRST_LOW,
      S_HWRST_WAIT,
      S_LOAD,
      S_SHIFT,
      S_GAP,
      S_DELAY,
      S_DONE
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [DW-1:0]   r_div;
   logic [3:0]      r_idx;
   logic [2:0]      r_bit;
   logic [6:0]      r_shift;

   logic            w_dc;
   logic            w_dly;
   logic [7:0]      w_byte;
   logic            w_last;

   // Init table: {dc, byte, delay flag} per entry
   always_comb begin
      w_dc   = 1'b0;
      w_byte = 8'h00;
      w_dly  = 1'b0;
      case (r_idx)
         4'd0: begin w_byte = 8'h01; w_dly = 1'b1; end
         4'd1: begin w_byte = 8'h11; w_dly = 1'b1; end
         4'd2: begin w_byte = 8'h3A; end
         4'd3: begin w_byte = COLMOD_VAL; w_dc = 1'b1; end
         4'd4: begin w_byte = 8'h36; end
         4'd5: begin w_byte = MADCTL_VAL; w_dc = 1'b1; end
         4'd6: begin w_byte = 8'h21; end
         4'd7: begin w_byte = 8'h13; end
         4'd8: begin w_byte = 8'h29; w_dly = 1'b1; end
         default: ;
      endcase
   end

   assign w_last = (r_idx == LAST_IDX);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_div     <= '0;
         r_idx     <= '0;
         r_bit     <= '0;
         r_shift   <= '0;
         o_lcd_rst <= 1'b1;
         o_sclk    <= 1'b0;
         o_mosi    <= 1'b0;
         o_dc      <= 1'b0;
         o_cs      <= 1'b1;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  o_lcd_rst <= 1'b0;
                  o_busy    <= 1'b1;
                  r_cnt     <= CW'(RST_PULSE - 1);
                  r_idx     <= '0;
                  r_state   <= S_HWRST_LOW;
               end
            end

            S_HWRST_LOW: begin
               if (r_cnt == '0) begin
                  o_lcd_rst <= 1'b1;
                  r_cnt     <= CW'(RST_WAIT - 1);
                  r_state   <= S_HWRST_WAIT;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end

            S_HWRST_WAIT: begin
               if (r_cnt == '0) begin
                  r_idx   <= '0;
                  r_state <= S_LOAD;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end

            S_LOAD: begin
               o_cs    <= 1'b0;
               o_dc    <= w_dc;
               o_sclk  <= 1'b0;
               o_mosi  <= w_byte[7];
               r_shift <= w_byte[6:0];
               r_bit   <= '0;
               r_div   <= DW'(CLK_DIV - 1);
               r_state <= S_SHIFT;
            end

            S_SHIFT: begin
               if (r_div == '0) begin
                  r_div  <= DW'(CLK_DIV - 1);
                  o_sclk <= ~o_sclk;
                  // data only moves on the falling edge so it is stable at the panel's rising sample
                  if (o_sclk) begin
                     if (r_bit == 3'd7) begin
                        o_cs    <= 1'b1;
                        o_mosi  <= 1'b0;
                        r_state <= S_GAP;
                     end else begin
                        r_bit   <= r_bit + 3'd1;
                        o_mosi  <= r_shift[6];
                        r_shift <= {r_shift[5:0], 1'b0};
                     end
                  end
               end else begin
                  r_div <= r_div - DW'(1);
               end
            end

            S_GAP: begin
               if (r_div == '0) begin
                  if (w_dly) begin
                     r_cnt   <= CW'(CMD_DELAY - 1);
                     r_state <= S_DELAY;
                  end else if (w_last) begin
                     r_state <= S_DONE;
                  end else begin
                     r_idx   <= r_idx + 4'd1;
                     r_state <= S_LOAD;
                  end
               end else begin
                  r_div <= r_div - DW'(1);
               end
            end

            S_DELAY: begin
               if (r_cnt == '0) begin
                  if (w_last) begin
                     r_state <= S_DONE;
                  end else begin
                     r_idx   <= r_idx + 4'd1;
                     r_state <= S_LOAD;
                  end
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end

            S_DONE: begin
               o_done  <= 1'b1;
               o_busy  <= 1'b0;
               o_dc    <= 1'b0;
               r_state <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
